// File: rtl/huffman_tree_builder.sv
// huffman_tree_builder: assigns canonical codes from serial code lengths and writes the {node,bit} decode table
module huffman_tree_builder #(
  parameter int NUMCODES = 288,
  parameter int OUTWIDTH = 10,
  parameter int MAXLEN = 15,
  localparam int SW = $clog2(NUMCODES + 1),
  localparam int AW = $clog2(2 * NUMCODES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                istart,
  input  logic [SW-1:0]       inum,
  input  logic                ien,
  input  logic [3:0]          ilen,
  output logic                obusy,
  output logic                odone,
  output logic                oerr,
  output logic                wen,
  output logic [AW-1:0]       waddr,
  output logic [OUTWIDTH-1:0] wdata,
  output logic [AW-1:0]       rdaddr,
  input  logic [OUTWIDTH-1:0] rddata
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, CLEAR = 3'd2, NEXTC = 3'd3, WALK = 3'd4;
  localparam int LW = $clog2(NUMCODES);
  localparam int TW = AW - 1;
  localparam int CW = MAXLEN + 1;
  localparam logic [OUTWIDTH-1:0] S = '1;
  logic [2:0] state;
  logic [SW-1:0] num, sym;
  logic [AW-1:0] cnt;
  logic [3:0] b, bitn, len, bi;
  logic [TW-1:0] treepos, node;
  logic [CW-1:0] code, prev, nc, cur;
  logic ph, cbit, last, sym_end;
  logic [3:0] lens [NUMCODES];
  logic [SW-1:0] bl_count [1:MAXLEN];
  logic [CW-1:0] next_code [1:MAXLEN];
  assign obusy = state != IDLE;
  // symbols beyond inum behave as unused, so the walk never needs lens cleared
  always_comb begin
    len = sym < num ? lens[LW'(sym)] : 4'd0;
    cur = len != 4'd0 ? next_code[len] : '0;
    bi = len - bitn - 4'd1;
    cbit = cur[bi];
    last = bitn == len - 4'd1;
    sym_end = sym == SW'(NUMCODES - 1);
    prev = b > 4'd1 ? CW'(bl_count[b - 4'd1]) : '0;
    nc = (code + prev) << 1;
    rdaddr = state == WALK ? {treepos, cbit} : '0;
  end
  always_ff @(posedge clk)
    if (!istart && state == LOAD && ien && int'(ilen) <= MAXLEN) lens[LW'(sym)] <= ilen;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      num <= '0;
      sym <= '0;
      cnt <= '0;
      b <= '0;
      bitn <= '0;
      treepos <= '0;
      node <= '0;
      code <= '0;
      ph <= 1'b0;
      odone <= 1'b0;
      oerr <= 1'b0;
      wen <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      for (int k = 1; k <= MAXLEN; k++) begin
        bl_count[k] <= '0;
        next_code[k] <= '0;
      end
    end else begin
      odone <= 1'b0;
      oerr <= 1'b0;
      wen <= 1'b0;
      if (istart) begin
        state <= inum == '0 ? CLEAR : LOAD;
        num <= inum;
        sym <= '0;
        node <= '0;
        cnt <= '0;
        for (int k = 1; k <= MAXLEN; k++) bl_count[k] <= '0;
      end else begin
        case (state)
          LOAD: if (ien) begin
            if (int'(ilen) > MAXLEN) begin
              oerr <= 1'b1;
              state <= IDLE;
            end else begin
              if (ilen != 4'd0) bl_count[ilen] <= bl_count[ilen] + 1'b1;
              sym <= sym + 1'b1;
              if (sym + 1'b1 == num) state <= CLEAR;
            end
          end
          CLEAR: begin
            wen <= 1'b1;
            waddr <= cnt;
            wdata <= S;
            cnt <= cnt + 1'b1;
            if (cnt == AW'(2 * NUMCODES - 1)) begin
              state <= NEXTC;
              b <= 4'd1;
              code <= '0;
            end
          end
          NEXTC: begin
            code <= nc;
            next_code[b] <= nc;
            b <= b + 4'd1;
            if (b == 4'(MAXLEN)) begin
              state <= WALK;
              sym <= '0;
              treepos <= '0;
              bitn <= '0;
              ph <= 1'b0;
            end
          end
          WALK: if (!ph) begin
            if (len == 4'd0) begin
              sym <= sym + 1'b1;
              if (sym_end) begin
                odone <= 1'b1;
                state <= IDLE;
              end
            end else ph <= 1'b1;
          end else begin
            ph <= 1'b0;
            // the branch taken depends on what earlier codes already placed at {treepos,bit}
            if (rddata == S && last) begin
              wen <= 1'b1;
              waddr <= {treepos, cbit};
              wdata <= OUTWIDTH'(sym);
              treepos <= '0;
              bitn <= '0;
              next_code[len] <= next_code[len] + 1'b1;
              sym <= sym + 1'b1;
              if (sym_end) begin
                odone <= 1'b1;
                state <= IDLE;
              end
            end else if (rddata == S && int'(node) < NUMCODES - 2) begin
              node <= node + 1'b1;
              wen <= 1'b1;
              waddr <= {treepos, cbit};
              wdata <= OUTWIDTH'(NUMCODES + int'(node) + 1);
              treepos <= node + 1'b1;
              bitn <= bitn + 4'd1;
            end else if (rddata != S && rddata >= OUTWIDTH'(NUMCODES) && !last) begin
              treepos <= TW'(rddata - OUTWIDTH'(NUMCODES));
              bitn <= bitn + 4'd1;
            end else begin
              oerr <= 1'b1;
              state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_huffman_tree_builder.sv
// tb_huffman_tree_builder: random and directed builds checked against a direct tree-insertion model
module tb_huffman_tree_builder;
  localparam int N = 8, OW = 10, ML = 15, AW = 4, SW = 4;
  localparam int S = 1023;
  logic clk = 1'b0, rst = 1'b1, istart = 1'b0, ien = 1'b0;
  logic [SW-1:0] inum = '0;
  logic [3:0] ilen = '0;
  logic obusy, odone, oerr, wen;
  logic [AW-1:0] waddr, rdaddr;
  logic [OW-1:0] wdata, rddata;
  logic [OW-1:0] mem [16];
  int tests = 0, fails = 0;
  int lv [N];
  int exp_tab [16];
  bit exp_err;
  int exp_lat;
  int rfc_tab [16] = '{9, 11, 5, 10, 0, 1, 12, 13, 2, 3, 4, 14, 6, 7, S, S};

  huffman_tree_builder #(.NUMCODES(N), .OUTWIDTH(OW), .MAXLEN(ML)) dut (
    .clk(clk), .rst(rst), .istart(istart), .inum(inum), .ien(ien), .ilen(ilen),
    .obusy(obusy), .odone(odone), .oerr(oerr), .wen(wen), .waddr(waddr),
    .wdata(wdata), .rdaddr(rdaddr), .rddata(rddata)
  );

  always #5 clk = ~clk;

  // write-first synchronous table RAM
  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rddata <= (wen && waddr == rdaddr) ? wdata : mem[rdaddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // canonical codes from the length histogram, then each code inserted into the table bit by bit
  task automatic model(input int n);
    int cnt [16];
    int nc [16];
    int code, pos, node, a, bv, len;
    bit last;
    exp_err = 0;
    node = 0;
    exp_lat = n + 2 * N + ML;
    for (int i = 0; i < 16; i++) begin
      cnt[i] = 0;
      nc[i] = 0;
      exp_tab[i] = S;
    end
    for (int s = 0; s < n; s++) if (lv[s] != 0) cnt[lv[s]]++;
    code = 0;
    for (int bl = 1; bl <= ML; bl++) begin
      code = ((code + (bl > 1 ? cnt[bl - 1] : 0)) << 1) & 16'hFFFF;
      nc[bl] = code;
    end
    for (int s = 0; s < N && !exp_err; s++) begin
      len = s < n ? lv[s] : 0;
      if (len == 0) exp_lat += 1;
      else begin
        exp_lat += 2 * len;
        pos = 0;
        for (int i = 0; i < len && !exp_err; i++) begin
          bv = (nc[len] >> (len - 1 - i)) & 1;
          a = 2 * pos + bv;
          last = i == len - 1;
          if (exp_tab[a] == S) begin
            if (last) exp_tab[a] = s;
            else if (node + 1 > N - 2) exp_err = 1;
            else begin
              node++;
              exp_tab[a] = N + node;
              pos = node;
            end
          end else if (exp_tab[a] >= N && !last) pos = exp_tab[a] - N;
          else exp_err = 1;
        end
        nc[len]++;
      end
    end
  endtask

  function automatic int decode(input int code, input int nb);
    int pos, e;
    pos = 0;
    for (int i = 0; i < nb; i++) begin
      e = int'(mem[2 * pos + ((code >> (nb - 1 - i)) & 1)]);
      if (e < N) return e;
      pos = e - N;
    end
    return -1;
  endfunction

  task automatic start(input int n);
    @(negedge clk);
    istart = 1'b1;
    inum = SW'(n);
    @(negedge clk);
    istart = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    int cyc;
    model(n);
    start(n);
    check({tag, ".busy_start"}, obusy, 1);
    cyc = 0;
    while (cyc < 2000 && !odone && !oerr) begin
      ien = cyc < n;
      ilen = cyc < n ? 4'(lv[cyc]) : 4'd0;
      @(negedge clk);
      cyc++;
    end
    ien = 1'b0;
    check({tag, ".done"}, odone, int'(!exp_err));
    check({tag, ".err"}, oerr, int'(exp_err));
    check({tag, ".busy_end"}, obusy, 0);
    if (!exp_err) check({tag, ".latency"}, cyc, exp_lat);
    @(negedge clk);
    check({tag, ".pulse"}, odone | oerr, 0);
    if (!exp_err) for (int a = 0; a < 16; a++) check($sformatf("%s.tab%0d", tag, a), mem[a], exp_tab[a]);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset.out", {obusy, odone, oerr, wen, waddr, wdata, rdaddr}, 0);
    rst = 1'b0;
    lv = '{3, 3, 3, 3, 3, 2, 4, 4};
    run(8, "rfc");
    for (int a = 0; a < 16; a++) check($sformatf("rfc.lit%0d", a), mem[a], rfc_tab[a]);
    check("rfc.dec1111", decode(4'b1111, 4), 7);
    check("rfc.dec00", decode(0, 2), 5);
    lv = '{1, 1, 1, 0, 0, 0, 0, 0};
    run(3, "oversub");
    check("oversub.err_model", int'(exp_err), 1);
    lv = '{0, 0, 0, 0, 0, 0, 0, 0};
    run(0, "empty");
    check("empty.lat", exp_lat, 2 * N + ML + N);
    lv = '{3, 3, 3, 3, 3, 2, 4, 4};
    start(8);
    for (int c = 0; c < 45; c++) begin
      ien = c < 8;
      ilen = c < 8 ? 4'(lv[c]) : 4'd0;
      @(negedge clk);
    end
    ien = 1'b0;
    check("abort.midwalk_busy", obusy, 1);
    lv = '{1, 1, 0, 0, 0, 0, 0, 0};
    run(2, "abort");
    check("abort.t0", mem[0], 0);
    check("abort.t1", mem[1], 1);
    start(0);
    repeat (5) @(negedge clk);
    check("clr.wen", wen, 1);
    #2 rst = 1'b1;
    #1;
    check("rstclr.busy", obusy, 0);
    check("rstclr.wen", wen, 0);
    check("rstclr.waddr", waddr, 0);
    check("rstclr.wdata", wdata, 0);
    check("rstclr.rdaddr", rdaddr, 0);
    check("rstclr.pulses", odone | oerr, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      ien = 1'b1;
      ilen = 4'(c + 1);
      @(negedge clk);
      check("rstclr.ien_ignored", {obusy, wen, odone, oerr}, 0);
    end
    ien = 1'b0;
    for (int t = 0; t < 30; t++) begin
      int n, budget, l;
      n = $urandom_range(N, 0);
      budget = 16;
      for (int s = 0; s < N; s++) begin
        if (t % 3 == 0) l = $urandom_range(4, 0);
        else if (t % 3 == 1) begin
          l = $urandom_range(4, 0);
          if (l != 0 && (16 >> l) > budget) l = 0;
          budget -= l != 0 ? 16 >> l : 0;
        end else l = $urandom_range(3, 0) == 0 ? $urandom_range(15, 5) : $urandom_range(4, 0);
        lv[s] = l;
      end
      run(n, $sformatf("rnd%0d", t));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/huffman_tree_builder.md
Name: huffman_tree_builder

Overview:
- Builds the 2-D Huffman lookup table that the Huffman bit-serial decoder walks; sits directly upstream of the decoder.
- Accepts per-symbol code lengths serially and assigns canonical (DEFLATE) codes. Writes tree nodes into a shared table RAM of 2*NUMCODES entries.
- Table format: entry value < NUMCODES is a leaf symbol. Entry value >= NUMCODES means "next node = value-NUMCODES". Address = {node, bit}.

Parameters:
NUMCODES, 288, number of symbols in the alphabet.
OUTWIDTH, 10, table entry width; 2^OUTWIDTH-1 > 2*NUMCODES-2 is required.
MAXLEN, 15, maximum code length.
AW (derived), clogb2(2*NUMCODES-1), table address width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
istart  in  1  pulse: abort any build, begin a new one; samples inum
inum  in  clogb2(NUMCODES)  number of lengths that follow (0..NUMCODES)
ien  in  1  ilen valid
ilen  in  4  code length of next symbol (0 = unused)
obusy  out  1  high from istart until odone/oerr
odone  out  1  one-cycle pulse: table complete
oerr  out  1  one-cycle pulse: over-subscribed/invalid lengths, build aborted
wen  out  1  table write enable
waddr  out  AW  table write address
wdata  out  OUTWIDTH  table write data
rdaddr  out  AW  table read address
rddata  in  OUTWIDTH  table read data, valid one cycle after rdaddr

Behaviour:
- Reset: state IDLE; obusy=0, odone=0, oerr=0, wen=0, waddr=0, wdata=0, rdaddr=0; all counters 0.
- istart is accepted in any state and overrides everything else in that cycle. It clears bl_count[*], the symbol counter and the node counter, latches inum, and enters LOAD. Reset mid-operation returns the block to IDLE.
- LOAD:
  - Each ien cycle stores ilen into internal length memory[sym], increments bl_count[ilen] when ilen!=0, and does sym++.
  - On the cycle the count reaches inum, or immediately if inum==0, go to CLEAR. ien is ignored outside LOAD.
  - Symbols >= inum are treated as length 0.
  - ilen > MAXLEN: oerr.
- CLEAR: writes sentinel S = 2^OUTWIDTH-1 to addresses 0..2*NUMCODES-1, one per cycle (wen=1). Then go to NEXTC.
- NEXTC:
  - One cycle per bit length b = 1..MAXLEN: code = (code + bl_count[b-1]) << 1, with bl_count[0] forced to 0; next_code[b] = code.
  - Code register width is MAXLEN+1.
  - Then go to WALK with sym=0, treepos=0.
- WALK, per symbol:
  - len = 0, or sym >= inum: skip, 1 cycle.
  - Otherwise, for i = 0..len-1: bit = next_code[len] bit (len-1-i).
  - Cycle A drives rdaddr = {treepos, bit}. Cycle B examines rddata:
    - rddata == S and last bit: write sym, treepos = 0.
    - rddata == S and not last: node++, write NUMCODES+node, treepos = node.
    - rddata >= NUMCODES and not S, and not last: treepos = rddata-NUMCODES, no write.
    - rddata < NUMCODES (leaf hit), or non-sentinel at last bit, or node > NUMCODES-2: oerr, go to IDLE.
  - After the last bit: next_code[len]++, sym++.
  - After sym == NUMCODES: odone, go to IDLE.
- Writes are registered; a write in cycle B is visible to a read issued in the following cycle A. The RAM must be write-first or the address must differ.
- Incomplete (under-subscribed) codes are legal; unused entries stay S.
- Single-length-1 code: one leaf entry written, other entry S, no error.
- Latency: LOAD inum cycles + CLEAR 2*NUMCODES + NEXTC MAXLEN + WALK sum(2*len or 1).
- odone and oerr are mutually exclusive. obusy drops in the same cycle as either pulse.

Test Plan:
- RFC1951 example, NUMCODES=8, lengths 3,3,3,3,3,2,4,4 -> odone. Table must equal [9,11,5,10,0,1,12,13,2,3,4,14,6,7,S,S].
- Same table read back by the decoder with bits 1,1,1,1 -> symbol 7. Bits 0,0 -> symbol 5.
- Over-subscribed lengths 1,1,1 (NUMCODES=8, inum=3) -> oerr pulse, no odone, obusy low the next cycle.
- inum=0 -> table all S, odone after 2*NUMCODES+MAXLEN+NUMCODES cycles, no oerr.
- istart asserted mid-WALK, then valid lengths 1,1 -> previous build abandoned. Table[0]=0, table[1]=1, odone.
- rst asserted during CLEAR -> all outputs 0 immediately. ien pulses ignored until the next istart.
